// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB responder fronting a word-organised SRAM with byte-lane writes and programmable wait states.
// Define AHB_SLAVE_ERR_EN to build the ERROR response path for unaligned, oversize and out-of-range transfers.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADYIN,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP
);
    localparam int         BYTES     = DATA_WIDTH / 8;
    localparam int         OFF_BITS  = $clog2(BYTES);
    localparam int         IDX_BITS  = $clog2(MEM_DEPTH);
    localparam int         LOW_BITS  = OFF_BITS + IDX_BITS;
    localparam logic [2:0] MAX_SIZE  = 3'(OFF_BITS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

`ifdef AHB_SLAVE_ERR_EN
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} state_t;
`endif

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [LOW_BITS-1:0]   addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic [2:0]            size_eff;
    logic [BYTES-1:0]      strb;
    logic [IDX_BITS-1:0]   idx;
    logic                  commit;
    logic                  unused_inputs;

    assign accept        = HSEL & HREADYIN & HTRANS[1];
    assign unused_inputs = ^{HBURST, HPROT, HTRANS[0], HADDR};

`ifdef AHB_SLAVE_ERR_EN
    logic [1:0] resp_q;
    logic [7:0] size_mask;
    logic       addr_err;

    always_comb begin
        size_mask = (8'd1 << HSIZE) - 8'd1;
        addr_err  = (HSIZE > MAX_SIZE)
                 || ((HADDR[OFF_BITS-1:0] & size_mask[OFF_BITS-1:0]) != '0)
                 || ((HADDR >> LOW_BITS) != '0);
    end

    assign HRESP = resp_q;
`else
    assign HRESP = 2'b00;
`endif

    // Oversize transfers collapse to full width; low address bits are aligned implicitly by block compare.
    assign size_eff = (size_q > MAX_SIZE) ? MAX_SIZE : size_q;
    assign idx      = addr_q[LOW_BITS-1:OFF_BITS];

    always_comb begin
        strb = '0;
        for (int b = 0; b < BYTES; b++)
            strb[b] = ((b >> size_eff) == (int'(addr_q[OFF_BITS-1:0]) >> size_eff));
    end

    assign commit    = (state == ST_DATA) && write_q && HREADYIN;
    assign HRDATA    = (state == ST_DATA && !write_q) ? mem[idx] : '0;
    assign HREADYOUT = ready_q;

    // Array is not reset; a write only lands on the edge closing its DATA cycle, so a read accepted there sees it.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < BYTES; b++)
                if (strb[b])
                    mem[idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            ready_q  <= 1'b1;
`ifdef AHB_SLAVE_ERR_EN
            resp_q   <= 2'b00;
`endif
        end else begin
            case (state)
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state   <= ST_DATA;
                        ready_q <= 1'b1;
                    end
                end
`ifdef AHB_SLAVE_ERR_EN
                ST_ERR1: begin
                    state   <= ST_ERR2;
                    ready_q <= 1'b1;
                end
`endif
                default: begin
                    // IDLE, DATA and ERR2 only advance while the bus is ready; otherwise another slave owns the stall.
                    if (HREADYIN) begin
`ifdef AHB_SLAVE_ERR_EN
                        resp_q <= 2'b00;
`endif
                        if (accept) begin
                            addr_q  <= HADDR[LOW_BITS-1:0];
                            write_q <= HWRITE;
                            size_q  <= HSIZE;
`ifdef AHB_SLAVE_ERR_EN
                            if (addr_err) begin
                                state   <= ST_ERR1;
                                ready_q <= 1'b0;
                                resp_q  <= 2'b01;
                            end else
`endif
                            if (WAIT_STATES > 0) begin
                                state    <= ST_WAIT;
                                wait_cnt <= WAIT_LOAD;
                                ready_q  <= 1'b0;
                            end else begin
                                state   <= ST_DATA;
                                ready_q <= 1'b1;
                            end
                        end else begin
                            state   <= ST_IDLE;
                            ready_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: two slaves (0 and 3 wait states) on a shared AHB bus with a small response mux.
// Directed steps in one initial block; AHB_SLAVE_ERR_EN selects the matching expectations.
module tb_ahb_sram_slave;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        hsel0, hsel3;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] rdata0, rdata3, hrdata;
    logic        rdy0, rdy3, hready;
    logic [1:0]  resp0, resp3, hresp;
    logic [1:0]  dsel;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_sram_slave #(.WAIT_STATES(0)) u_ws0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADYIN(hready), .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
    );

    ahb_sram_slave #(.WAIT_STATES(3)) u_ws3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADYIN(hready), .HRDATA(rdata3), .HREADYOUT(rdy3), .HRESP(resp3)
    );

    // Response mux follows whichever slave owns the current data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            dsel <= 2'd0;
        else if (hready)
            dsel <= hsel0 ? 2'd1 : (hsel3 ? 2'd2 : 2'd0);
    end

    assign hready = (dsel == 2'd1) ? rdy0   : (dsel == 2'd2) ? rdy3   : 1'b1;
    assign hrdata = (dsel == 2'd1) ? rdata0 : (dsel == 2'd2) ? rdata3 : 32'h0;
    assign hresp  = (dsel == 2'd1) ? resp0  : (dsel == 2'd2) ? resp3  : 2'b00;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic [1:0] trans, input logic wr,
                                 input logic [2:0] size, input logic [31:0] addr);
        hsel0  = (sel == 1);
        hsel3  = (sel == 2);
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic single_write(input int sel, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] data);
        int n;
        applyStimulus(sel, 2'b10, 1'b1, size, addr);
        step();
        applyStimulus(sel, 2'b00, 1'b0, 3'b010, 32'h0);
        HWDATA = data;
        n = 0;
        while (hready !== 1'b1 && n < 32) begin
            step();
            n++;
        end
        checkOutput("wr_bound", 32'(n < 32), 32'd1);
        step();
    endtask

    task automatic single_read(input int sel, input logic [31:0] addr, output logic [31:0] data);
        int n;
        applyStimulus(sel, 2'b10, 1'b0, 3'b010, addr);
        step();
        applyStimulus(sel, 2'b00, 1'b0, 3'b010, 32'h0);
        n = 0;
        while (hready !== 1'b1 && n < 32) begin
            step();
            n++;
        end
        checkOutput("rd_bound", 32'(n < 32), 32'd1);
        data = hrdata;
        step();
    endtask

    logic [31:0] rd;
    logic [31:0] vals [4];
    int          low;
    int          total;

    initial begin
        vals[0] = 32'h1000_0001;
        vals[1] = 32'h2000_0002;
        vals[2] = 32'h3000_0003;
        vals[3] = 32'h4000_0004;
        HRESETn = 1'b0;
        HBURST  = 3'b000;
        HPROT   = 4'b0011;
        HWDATA  = 32'h0;
        applyStimulus(0, 2'b00, 1'b0, 3'b010, 32'h0);
        step();
        step();
        checkOutput("rst_rdy0", 32'(rdy0), 32'd1);
        checkOutput("rst_rdy3", 32'(rdy3), 32'd1);
        checkOutput("rst_resp0", 32'(resp0), 32'd0);
        checkOutput("rst_resp3", 32'(resp3), 32'd0);
        checkOutput("rst_rdata0", rdata0, 32'h0);
        checkOutput("rst_rdata3", rdata3, 32'h0);
        HRESETn = 1'b1;
        step();

        $display("[TB] zero wait states: write then back-to-back read");
        applyStimulus(1, 2'b10, 1'b1, 3'b010, 32'h04);
        step();
        HWDATA = 32'hDEAD_BEEF;
        checkOutput("t2_wr_rdy", 32'(rdy0), 32'd1);
        applyStimulus(1, 2'b10, 1'b0, 3'b010, 32'h04);
        step();
        checkOutput("t2_rd_rdy", 32'(rdy0), 32'd1);
        checkOutput("t2_rd_data", rdata0, 32'hDEAD_BEEF);
        applyStimulus(1, 2'b00, 1'b0, 3'b010, 32'h0);
        step();
        checkOutput("t2_idle_rdy", 32'(rdy0), 32'd1);
        checkOutput("t2_idle_data", rdata0, 32'h0);

        $display("[TB] byte lanes");
        applyStimulus(1, 2'b10, 1'b1, 3'b010, 32'h08);
        step();
        HWDATA = 32'h1122_3344;
        applyStimulus(1, 2'b10, 1'b1, 3'b000, 32'h0A);
        step();
        HWDATA = 32'h00AA_0000;
        applyStimulus(1, 2'b10, 1'b0, 3'b010, 32'h08);
        step();
        checkOutput("t3_byte_merge", rdata0, 32'h11AA_3344);
        applyStimulus(1, 2'b00, 1'b0, 3'b010, 32'h0);
        step();
        single_write(1, 32'h0C, 3'b010, 32'hCAFE_F00D);
        single_write(1, 32'h0E, 3'b001, 32'hBEEF_0000);
        single_read(1, 32'h0C, rd);
        checkOutput("t3_half_upper", rd, 32'hBEEF_F00D);
`ifndef AHB_SLAVE_ERR_EN
        single_read(1, 32'h0000_1008, rd);
        checkOutput("t3_wrap", rd, 32'h11AA_3344);
        single_write(1, 32'h0C, 3'b011, 32'h0123_4567);
        single_read(1, 32'h0C, rd);
        checkOutput("t3_oversize_full", rd, 32'h0123_4567);
`endif

        $display("[TB] unaligned word write");
        single_write(1, 32'h00, 3'b010, 32'h0BAD_F00D);
        applyStimulus(1, 2'b10, 1'b1, 3'b010, 32'h02);
        step();
        HWDATA = 32'h5566_7788;
        applyStimulus(1, 2'b00, 1'b0, 3'b010, 32'h0);
`ifdef AHB_SLAVE_ERR_EN
        checkOutput("t5_err1_rdy", 32'(rdy0), 32'd0);
        checkOutput("t5_err1_resp", 32'(resp0), 32'd1);
        step();
        checkOutput("t5_err2_rdy", 32'(rdy0), 32'd1);
        checkOutput("t5_err2_resp", 32'(resp0), 32'd1);
        step();
        single_read(1, 32'h00, rd);
        checkOutput("t5_mem_kept", rd, 32'h0BAD_F00D);
`else
        checkOutput("t5_ok_rdy", 32'(rdy0), 32'd1);
        checkOutput("t5_ok_resp", 32'(resp0), 32'd0);
        step();
        single_read(1, 32'h00, rd);
        checkOutput("t5_masked_write", rd, 32'h5566_7788);
`endif

        $display("[TB] idle, busy and deselected transfers");
        HWDATA = 32'h0;
        applyStimulus(1, 2'b01, 1'b1, 3'b010, 32'h04);
        step();
        checkOutput("t6_busy_rdy", 32'(rdy0), 32'd1);
        checkOutput("t6_busy_resp", 32'(resp0), 32'd0);
        applyStimulus(1, 2'b00, 1'b1, 3'b010, 32'h04);
        step();
        checkOutput("t6_idle_rdy", 32'(rdy0), 32'd1);
        checkOutput("t6_idle_resp", 32'(resp0), 32'd0);
        applyStimulus(0, 2'b10, 1'b1, 3'b010, 32'h04);
        step();
        checkOutput("t6_nosel_rdy", 32'(rdy0), 32'd1);
        step();
        single_read(1, 32'h04, rd);
        checkOutput("t6_mem_kept", rd, 32'hDEAD_BEEF);

        $display("[TB] three wait states: INCR4 read burst");
        for (int k = 0; k < 4; k++)
            single_write(2, 32'h20 + 32'(4 * k), 3'b010, vals[k]);
        HBURST = 3'b011;
        applyStimulus(2, 2'b10, 1'b0, 3'b010, 32'h20);
        step();
        total = 0;
        applyStimulus(2, 2'b11, 1'b0, 3'b010, 32'h24);
        for (int k = 0; k < 4; k++) begin
            low = 0;
            while (hready !== 1'b1 && low < 20) begin
                low++;
                step();
                total++;
            end
            checkOutput($sformatf("t4_low%0d", k), 32'(low), 32'd3);
            checkOutput($sformatf("t4_data%0d", k), hrdata, vals[k]);
            step();
            total++;
            if (k < 2)
                applyStimulus(2, 2'b11, 1'b0, 3'b010, 32'h20 + 32'(4 * (k + 2)));
            else
                applyStimulus(2, 2'b00, 1'b0, 3'b010, 32'h0);
        end
        checkOutput("t4_total_cycles", 32'(total), 32'd16);
        HBURST = 3'b000;

        $display("[TB] reset during wait states");
        single_write(2, 32'h10, 3'b010, 32'hA5A5_A5A5);
        applyStimulus(2, 2'b10, 1'b1, 3'b010, 32'h10);
        step();
        HWDATA = 32'h1234_5678;
        applyStimulus(2, 2'b00, 1'b0, 3'b010, 32'h0);
        step();
        checkOutput("t1_in_wait", 32'(rdy3), 32'd0);
        #2;
        HRESETn = 1'b0;
        #1;
        checkOutput("t1_rst_rdy", 32'(rdy3), 32'd1);
        checkOutput("t1_rst_resp", 32'(resp3), 32'd0);
        checkOutput("t1_rst_rdata", rdata3, 32'h0);
        applyStimulus(0, 2'b00, 1'b0, 3'b010, 32'h0);
        step();
        step();
        HRESETn = 1'b1;
        step();
        single_read(2, 32'h10, rd);
        checkOutput("t1_write_dropped", rd, 32'hA5A5_A5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
